// File: rtl/ff_pkg.sv
// Shared constants for the multimode flip-flop bank: mode encodings and the
// debounce length used when building for the board.
package ff_pkg;
  localparam logic [1:0] MODE_D  = 2'd0;
  localparam logic [1:0] MODE_JK = 2'd1;
  localparam logic [1:0] MODE_T  = 2'd2;
  localparam logic [1:0] MODE_SR = 2'd3;

  // Roughly 10-20 ms of button stability at typical board clock rates.
  localparam int BOARD_DEBOUNCE_CYCLES = 1000000;
endpackage

// File: rtl/multimode_ff_bank_if.sv
// Switch/LED side of the flip-flop bank: mode and a/b in, q/notq and status out.
interface multimode_ff_bank_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] notq;
  logic             step;
  logic             sr_conflict;

  modport master (
    output mode, a, b,
    input  q, notq, step, sr_conflict
  );

  modport slave (
    input  mode, a, b,
    output q, notq, step, sr_conflict
  );
endinterface

// File: rtl/multimode_ff_bank_btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and a one-cycle
// pulse on each accepted press (rising edge of the debounced level only).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic step
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             btn_s;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // A level change is accepted once it has been seen for DEBOUNCE_CYCLES cycles.
  assign accept = (btn_s != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      btn_s  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      step   <= 1'b0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
      step  <= accept && btn_s;
      if (btn_s == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= btn_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/multimode_ff_bank.sv
// WIDTH-bit register bank whose bits behave as D, JK, T or SR flip-flops,
// advancing one step per debounced button press on the board clock.
module multimode_ff_bank
  import ff_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn,
  multimode_ff_bank_if.slave  bus
);
  logic             step;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             sr_conflict_r;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .step  (step)
  );

  always_comb begin
    q_next = q_r;
    for (int i = 0; i < WIDTH; i++) begin
      case (bus.mode)
        MODE_D:  q_next[i] = bus.a[i];
        MODE_JK: begin
          case ({bus.a[i], bus.b[i]})
            2'b01:   q_next[i] = 1'b0;
            2'b10:   q_next[i] = 1'b1;
            2'b11:   q_next[i] = ~q_r[i];
            default: q_next[i] = q_r[i];
          endcase
        end
        MODE_T:  q_next[i] = bus.a[i] ? ~q_r[i] : q_r[i];
        default: begin
          // SR with both inputs high is illegal; the bit simply holds.
          case ({bus.a[i], bus.b[i]})
            2'b01:   q_next[i] = 1'b0;
            2'b10:   q_next[i] = 1'b1;
            default: q_next[i] = q_r[i];
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r           <= '0;
      sr_conflict_r <= 1'b0;
    end else if (step) begin
      q_r           <= q_next;
      sr_conflict_r <= (bus.mode == MODE_SR) && |(bus.a & bus.b);
    end
  end

  assign bus.q           = q_r;
  assign bus.notq        = ~q_r;
  assign bus.step        = step;
  assign bus.sr_conflict = sr_conflict_r;
endmodule

// File: doc/multimode_ff_bank.md
Name: multimode_ff_bank

Overview:
- WIDTH-bit register bank; every bit acts as a D, JK, T or SR flip-flop, selected by a shared mode input.
- The bank runs on the board clock. A debounced push-button produces a single-cycle step pulse, and the bank updates only on that pulse.
- Successor to the fixed single-bit D/JK/T flip-flop demo: parametrised width, runtime mode select, SR mode, and no button-as-clock.
- Top level wires switches to a/b/mode and LEDs to q/notq.

Parameters:
- WIDTH, 4: number of flip-flop bits.
- DEBOUNCE_CYCLES, 4: consecutive stable clk cycles needed to accept a button level change. Board build overrides this to 1000000. Minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width (derived; do not override).

Ports:
- clk, input, 1: board clock; all state on rising edge.
- reset, input, 1: asynchronous, active-high; clears all state.
- btn, input, 1: raw, asynchronous, bouncy step button.
- mode, input, 2: 0=D, 1=JK, 2=T, 3=SR.
- a, input, WIDTH: D data / J / T-enable / S, per bit.
- b, input, WIDTH: K / R per bit; ignored in D and T modes.
- q, output, WIDTH: flip-flop state.
- notq, output, WIDTH: always ~q.
- step, output, 1: one-cycle pulse, debounced button press accepted.
- sr_conflict, output, 1: last SR step had some bit with a=b=1.

Behaviour:
- Reset (async assert, sync to clk on release): q=0, notq=all 1s, step=0, sr_conflict=0, sync flops=0, stable=0, counter=0.
- Synchroniser: btn passes through 2 flops to give btn_s. No logic on the raw btn.
- Debounce counter (cnt):
  - If btn_s==stable: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: stable<=btn_s, cnt<=0.
  - Else cnt<=cnt+1.
  - cnt never wraps.
- step is registered: step<=1 on the edge where stable goes 0->1; otherwise step<=0.
  - Falling transitions of stable never produce step.
- Latency: btn rises just before edge 0 and is held. btn_s=1 after edge 1. stable and step are 1 after edge 1+DEBOUNCE_CYCLES. q updates at edge 2+DEBOUNCE_CYCLES.
- Glitches: a btn_s excursion shorter than DEBOUNCE_CYCLES cycles resets cnt and produces no step. Bounce during release is likewise absorbed.
- Update, only on the edge where step==1; mode, a and b are sampled on that same edge. Per bit i:
  - D: q[i]<=a[i].
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - T: a[i] ? ~q[i] : q[i].
  - SR: 00 hold, 01 clear, 10 set, 11 hold (illegal).
- sr_conflict:
  - On a step edge: <= (mode==SR) && |(a&b).
  - Otherwise holds. Cleared only by reset or by the next non-conflicting step.
- With step==0, q holds regardless of a, b or mode changes.
- notq is combinational ~q; it must never equal q.
- Reset mid-debounce: counter and stable clear. A button still held after reset release counts as a fresh press and yields one step after the full latency.
- Holding btn indefinitely yields exactly one step per press.

Decomposition:
- Package ff_pkg: mode localparams MODE_D=2'd0, MODE_JK=2'd1, MODE_T=2'd2, MODE_SR=2'd3. Also the default DEBOUNCE_CYCLES constant used by the top-level board build.
- Sub-module btn_debounce (params DEBOUNCE_CYCLES):
  - Ports clk, reset, btn, step.
  - Contains the synchroniser, counter, stable register and edge detect.
  - Reusable for other button-driven blocks.
- Next-state logic in multimode_ff_bank: one case on mode inside a per-bit generate or for loop.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4):
- Reset then D mode: a=4'b1010, btn held high 10 cycles -> exactly one step pulse, 6 clk edges after btn rise; q=1010 and notq=0101 on the following edge.
- Bounce rejection: btn toggles high/low every 2 cycles for 20 cycles, then stays low -> no step; q unchanged.
- JK mode: q=1010, a=4'b0110, b=4'b0011, one press -> q=1100 (bit3 hold, bit2 set, bit1 toggle, bit0 clear).
- T mode: q=0000, a=4'b0101, three presses -> q=0101, 0000, 0101. Changing a between presses without a press leaves q unchanged.
- SR mode: q=1100, a=4'b0011, b=4'b0110, press -> q=1001 (bit2 cleared, bit1 held), sr_conflict=1. Next press with a=4'b0001, b=0 -> q=1001, sr_conflict=0.
- Async reset asserted mid-debounce (cnt=2) with q=1111 -> q=0, notq=1111 immediately without a clk edge. btn still held after release -> one step after the full 6-cycle latency.
